fifo_burst_writer: RTL and testbench

Write-side burst producer for the asynchronous FIFO, running entirely in the `wclk` domain. On a start command it pushes a programmed number of data words into the FIFO write port (`put` / `data_in`), throttling on the FIFO's `full_bar`. Words follow an arithmetic sequence (seed plus stride). It gives test benches and upstream logic a deterministic, back-pressure-aware writer, with a matching reader on the `rclk` side.

---
 rtl/fifo_burst_writer.sv | 130 +++++++++++++
 tb/tb_fifo_burst_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_writer.sv
// Write-side burst producer: pushes burst_len words (seed, seed+stride, ...) into the FIFO, stalling on full_bar.
// Define FIFO_WRITER_CHECKSUM_EN to append an XOR checksum word after the payload.
`timescale 1ns/1ps
module fifo_burst_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  wclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [DATA_WIDTH-1:0] stride,
  input  logic                  full_bar,
  output logic                  put,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_written
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CSUM  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  put_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_inc;
  logic                  accept;
`ifdef FIFO_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  // put_q is a register, so acceptance only combines two already-stable values
  assign accept  = put_q & full_bar;
  assign cnt_inc = cnt_q + LEN_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
`ifdef FIFO_WRITER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = burst_len;
          stride_d = stride;
          data_d   = seed;
          cnt_d    = '0;
`ifdef FIFO_WRITER_CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = (burst_len == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          data_d = data_q + stride_q;
          cnt_d  = cnt_inc;
`ifdef FIFO_WRITER_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
          if (cnt_inc == len_q) begin
            data_d  = csum_q ^ data_q;
            state_d = S_CSUM;
          end
`else
          if (cnt_inc == len_q) state_d = S_DONE;
`endif
        end
        if (abort) state_d = S_IDLE;
      end
`ifdef FIFO_WRITER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = S_DONE;
        if (abort)  state_d = S_IDLE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change only on wclk
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      put_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
`ifdef FIFO_WRITER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      put_q    <= (state_d == S_WRITE) || (state_d == S_CSUM);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      data_q   <= data_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
`ifdef FIFO_WRITER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign put           = put_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign data_in       = data_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Randomised bench for fifo_burst_writer: the bench plays the FIFO and compares the accepted stream
// against the arithmetic sequence (plus XOR word when FIFO_WRITER_CHECKSUM_EN is defined).
`timescale 1ns/1ps
module tb_fifo_burst_writer;
  localparam int DW = 8;
  localparam int LW = 8;
`ifdef FIFO_WRITER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          wclk = 1'b0;
  logic          reset, start, abort, full_bar;
  logic [LW-1:0] burst_len;
  logic [DW-1:0] seed, stride;
  logic          put, busy, done;
  logic [DW-1:0] data_in;
  logic [LW-1:0] words_written;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] got[$];

  fifo_burst_writer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .wclk(wclk), .reset(reset), .start(start), .abort(abort),
    .burst_len(burst_len), .seed(seed), .stride(stride), .full_bar(full_bar),
    .put(put), .data_in(data_in), .busy(busy), .done(done),
    .words_written(words_written)
  );

  always #5 wclk = ~wclk;

  // mode: 0 = FIFO never full, 1 = random back-pressure, 2 = full for 3 cycles after 2nd accept
  task automatic run_burst(input int len, input logic [DW-1:0] sd, input logic [DW-1:0] st,
                           input int mode, input int abort_at, input bit poke, input string nm);
    int stalls = 0, done_cnt = 0, done_j = -1, stall_left = 0, exp_n, payload;
    bit aborted = 0, stalled_once = 0, finished = 0;
    logic [DW-1:0] expq[$];
    logic [DW-1:0] w, x, e;
    got.delete();
    w = sd; x = '0;
    for (int i = 0; i < len; i++) begin
      expq.push_back(w);
      x = x ^ w;
      w = w + st;
    end
    burst_len = LW'(len); seed = sd; stride = st; start = 1'b1; full_bar = 1'b1; abort = 1'b0;
    @(posedge wclk); #1;
    start = 1'b0; burst_len = LW'($urandom); seed = DW'($urandom); stride = DW'($urandom);
    for (int j = 0; j < 2000; j++) begin
      case (mode)
        0: full_bar = 1'b1;
        1: full_bar = ($urandom_range(0, 9) < 7);
        default: begin
          if (!stalled_once && got.size() == 2) begin stall_left = 3; stalled_once = 1; end
          full_bar = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      abort = (abort_at >= 0 && !aborted && got.size() == abort_at);
      if (abort) aborted = 1;
      start = poke && (j == 1);
      @(negedge wclk);
      if (j == 0) begin
        checks++;
        if (busy !== 1'b1 || put !== (len != 0)) begin
          errors++;
          $display("FAIL %s first_cycle: busy=%b put=%b, required busy=1 put=%b", nm, busy, put, len != 0);
        end
      end
      if (j > 0 && !busy) begin finished = 1; break; end
      if (done) begin done_cnt++; done_j = j; end
      if (put && !full_bar) stalls++;
      if (put && full_bar) got.push_back(data_in);
      @(posedge wclk); #1;
    end
    abort = 1'b0; start = 1'b0; full_bar = 1'b1;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: busy still %b after 2000 cycles, required 0", nm, busy);
    end
    checks++;
    if (put !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_outputs: put=%b done=%b, required 0 0", nm, put, done);
    end
    exp_n = (len != 0) ? len + CS : 0;
    checks++;
    if (abort_at < 0) begin
      if (got.size() != exp_n) begin
        errors++;
        $display("FAIL %s word_count: got %0d words, required %0d", nm, got.size(), exp_n);
      end
    end else if (got.size() < abort_at || got.size() > abort_at + 1) begin
      errors++;
      $display("FAIL %s abort_count: got %0d words, required %0d or %0d", nm, got.size(), abort_at, abort_at + 1);
    end
    for (int i = 0; i < got.size(); i++) begin
      e = (i < len) ? expq[i] : x;
      checks++;
      if (got[i] !== e) begin
        errors++;
        $display("FAIL %s word[%0d]: got %h, required %h", nm, i, got[i], e);
      end
    end
    payload = (got.size() < len) ? got.size() : len;
    checks++;
    if (words_written !== LW'(payload)) begin
      errors++;
      $display("FAIL %s words_written: got %0d, required %0d", nm, words_written, payload);
    end
    checks++;
    if (done_cnt != ((abort_at < 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d, required %0d", nm, done_cnt, (abort_at < 0) ? 1 : 0);
    end
    if (abort_at < 0) begin
      checks++;
      if (done_j != exp_n + stalls) begin
        errors++;
        $display("FAIL %s done_timing: done at cycle %0d, required %0d", nm, done_j, exp_n + stalls);
      end
    end
    if (mode == 2) begin
      checks++;
      if (stalls != 3) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d, required 3", nm, stalls);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; full_bar = 1'b1;
    burst_len = '0; seed = '0; stride = '0;
    repeat (3) @(posedge wclk);
    #1;
    checks++;
    if ({put, busy, done, data_in, words_written} !== '0) begin
      errors++;
      $display("FAIL reset_values: put=%b busy=%b done=%b data=%h ww=%0d, required all 0",
               put, busy, done, data_in, words_written);
    end
    reset = 1'b0;
    @(posedge wclk); #1;
  endtask

  task automatic test_basic();
    run_burst(4, 8'h10, 8'h01, 0, -1, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_burst(3, 8'hFE, 8'h01, 0, -1, 1'b1, "wrap");
  endtask

  task automatic test_throttle();
    run_burst(5, 8'h00, 8'h01, 2, -1, 1'b0, "throttle");
  endtask

  task automatic test_abort();
    run_burst(8, 8'h40, 8'h05, 0, 3, 1'b0, "abort");
    run_burst(2, 8'h77, 8'h11, 0, -1, 1'b0, "after_abort");
  endtask

  task automatic test_zero_len();
    run_burst(0, 8'h55, 8'h02, 0, -1, 1'b0, "zero_len");
  endtask

  task automatic test_reset_mid_burst();
    int seen_bad = 0;
    burst_len = 8'd8; seed = 8'h20; stride = 8'h03; start = 1'b1; full_bar = 1'b1;
    @(posedge wclk); #1;
    start = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    checks++;
    if (words_written !== 8'd2 || data_in !== 8'h26) begin
      errors++;
      $display("FAIL midreset_pre: ww=%0d data=%h, required 2 26", words_written, data_in);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({put, busy, done, data_in, words_written} !== '0) begin
      errors++;
      $display("FAIL midreset_async: put=%b busy=%b done=%b data=%h ww=%0d, required all 0",
               put, busy, done, data_in, words_written);
    end
    @(negedge wclk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge wclk);
      if (put || done || busy) seen_bad++;
    end
    checks++;
    if (seen_bad != 0) begin
      errors++;
      $display("FAIL midreset_stays_idle: %0d active cycles after reset, required 0", seen_bad);
    end
    @(posedge wclk); #1;
    run_burst(4, 8'h90, 8'hF0, 1, -1, 1'b1, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int len = $urandom_range(1, 20);
      int ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_burst(len, DW'($urandom), DW'($urandom), 1, ab, (len > 3), "random");
    end
    run_burst(255, DW'($urandom), DW'($urandom), 1, -1, 1'b0, "max_len");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_throttle();
    test_abort();
    test_zero_len();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
